// File: rtl/alu_seq_controller_if.sv
// Handshake and operand/result bundle between a sequencer (master) and the
// sequenced ALU controller (slave).
interface alu_seq_controller_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] C_hi;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, op, A, B,
    input  C, C_hi, carry, overflow, zero, busy, done
  );

  modport slave (
    input  start, op, A, B,
    output C, C_hi, carry, overflow, zero, busy, done
  );
endinterface

// File: rtl/alu_seq_controller.sv
// Sequenced ALU execution unit: start/busy/done handshake, eight operations,
// single-cycle ops in 2 cycles and an LSB-first shift-add multiply in WIDTH+1.
module alu_seq_controller #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  alu_seq_controller_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXECUTE = 2'b01,
    ST_STORE   = 2'b10,
    ST_SPARE   = 2'b11
  } state_t;

  state_t             state_r, state_next_s;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [2:0]         op_r;
  logic [SHW-1:0]     cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   res_lo_r, res_hi_r;
  logic               res_carry_r, res_ovf_r;
  logic [WIDTH-1:0]   c_r, c_hi_r;
  logic               carry_r, overflow_r, zero_r, busy_r, done_r;

  logic               accept_s, last_bit_s;
  logic [WIDTH:0]     sum_s, diff_s;
  logic [2*WIDTH-1:0] mul_acc_s;
  logic [WIDTH-1:0]   alu_lo_s;
  logic               alu_carry_s, alu_ovf_s;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; the multiply stays in EXECUTE until its last multiplier bit
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_next_s = ST_EXECUTE;
        else           state_next_s = ST_IDLE;
      end
      ST_EXECUTE: begin
        if ((op_r != OP_MUL) || last_bit_s) state_next_s = ST_STORE;
        else                                state_next_s = ST_EXECUTE;
      end
      ST_STORE: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Combinational datapath: accept strobe, ALU result/flags and next multiply partial sum
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && bus.start;
    last_bit_s  = (cnt_r == SHW'(WIDTH - 1));
    sum_s       = {1'b0, a_r} + {1'b0, b_r};
    diff_s      = {1'b0, a_r} - {1'b0, b_r};
    mul_acc_s   = acc_r + (b_r[cnt_r] ? ({{WIDTH{1'b0}}, a_r} << cnt_r)
                                      : {(2*WIDTH){1'b0}});
    alu_lo_s    = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    case (op_r)
      OP_ADD: begin
        alu_lo_s    = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
        alu_ovf_s   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        alu_lo_s    = diff_s[WIDTH-1:0];
        alu_carry_s = diff_s[WIDTH];
        alu_ovf_s   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_AND:  alu_lo_s = a_r & b_r;
      OP_OR:   alu_lo_s = a_r | b_r;
      OP_XOR:  alu_lo_s = a_r ^ b_r;
      OP_SHL:  alu_lo_s = a_r << b_r[SHW-1:0];
      OP_SHR:  alu_lo_s = a_r >> b_r[SHW-1:0];
      default: alu_lo_s = {WIDTH{1'b0}};
    endcase
  end

  // Operand capture, execution registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      op_r        <= 3'd0;
      cnt_r       <= {SHW{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      res_lo_r    <= {WIDTH{1'b0}};
      res_hi_r    <= {WIDTH{1'b0}};
      res_carry_r <= 1'b0;
      res_ovf_r   <= 1'b0;
      c_r         <= {WIDTH{1'b0}};
      c_hi_r      <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= (state_r == ST_STORE);
      if (accept_s)                  busy_r <= 1'b1;
      else if (state_r == ST_STORE)  busy_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r   <= bus.A;
            b_r   <= bus.B;
            op_r  <= bus.op;
            cnt_r <= {SHW{1'b0}};
            acc_r <= {(2*WIDTH){1'b0}};
          end
        end
        ST_EXECUTE: begin
          if (op_r == OP_MUL) begin
            acc_r <= mul_acc_s;
            cnt_r <= cnt_r + SHW'(1);
            if (last_bit_s) begin
              res_lo_r    <= mul_acc_s[WIDTH-1:0];
              res_hi_r    <= mul_acc_s[2*WIDTH-1:WIDTH];
              res_carry_r <= |mul_acc_s[2*WIDTH-1:WIDTH];
              res_ovf_r   <= 1'b0;
            end
          end else begin
            res_lo_r    <= alu_lo_s;
            res_hi_r    <= {WIDTH{1'b0}};
            res_carry_r <= alu_carry_s;
            res_ovf_r   <= alu_ovf_s;
          end
        end
        ST_STORE: begin
          c_r        <= res_lo_r;
          c_hi_r     <= res_hi_r;
          carry_r    <= res_carry_r;
          overflow_r <= res_ovf_r;
          zero_r     <= ~|{res_hi_r, res_lo_r};
        end
        default: begin
          cnt_r <= {SHW{1'b0}};
        end
      endcase
    end
  end

  assign bus.C        = c_r;
  assign bus.C_hi     = c_hi_r;
  assign bus.carry    = carry_r;
  assign bus.overflow = overflow_r;
  assign bus.zero     = zero_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_alu_seq_controller.sv
// Self-checking bench for alu_seq_controller (WIDTH=8): directed table,
// random ops against an arithmetic model, and handshake corner cases.
module tb_alu_seq_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_controller_if #(.WIDTH(8)) bus_if ();
  alu_seq_controller #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus_if));

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, c, c_hi;
    logic       carry, ovf, zero;
    int         lat;
  } vec_t;

  vec_t sb[$];
  vec_t exp_v;
  vec_t tbl[13];
  int   checks = 0;
  int   errors = 0;
  int   pulses[4];
  int   np;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, b, c, hi,
                              input logic cy, ov, z, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.c = c; v.c_hi = hi;
    v.carry = cy; v.ovf = ov; v.zero = z; v.lat = lat;
    return v;
  endfunction

  // Reference model built on integer arithmetic
  function automatic vec_t model(input logic [2:0] op, input logic [7:0] a, b);
    vec_t v;
    int sa, sbb, sr;
    int unsigned p;
    v.op = op; v.a = a; v.b = b; v.c_hi = 8'h00;
    v.carry = 1'b0; v.ovf = 1'b0; v.lat = 2;
    sa = int'($signed(a)); sbb = int'($signed(b));
    p = 0; sr = 0;
    case (op)
      3'd0: begin p = a + b; v.c = p[7:0]; v.carry = (p > 255); sr = sa + sbb;
                  v.ovf = (sr > 127) || (sr < -128); end
      3'd1: begin p = a - b; v.c = p[7:0]; v.carry = (a < b); sr = sa - sbb;
                  v.ovf = (sr > 127) || (sr < -128); end
      3'd2: v.c = a & b;
      3'd3: v.c = a | b;
      3'd4: v.c = a ^ b;
      3'd5: begin p = a << (b % 8); v.c = p[7:0]; end
      3'd6: v.c = a >> (b % 8);
      default: begin p = a * b; v.c = p[7:0]; v.c_hi = p[15:8];
                     v.carry = (v.c_hi != 8'h00); v.lat = 9; end
    endcase
    v.zero = (v.c == 8'h00) && (v.c_hi == 8'h00);
    return v;
  endfunction

  // Scoreboard: every done pulse pops and compares one expected result
  always @(negedge clk) begin
    if (reset === 1'b1 && bus_if.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_v = sb.pop_front();
        check("C", bus_if.C, exp_v.c);
        check("C_hi", bus_if.C_hi, exp_v.c_hi);
        check("carry", bus_if.carry, exp_v.carry);
        check("overflow", bus_if.overflow, exp_v.ovf);
        check("zero", bus_if.zero, exp_v.zero);
      end
    end
  end

  // Issue one op at a negedge, optionally poking start while busy, and time it
  task automatic do_op(input vec_t v, input int poke);
    int n, busy_n;
    bus_if.start = 1'b1; bus_if.op = v.op; bus_if.A = v.a; bus_if.B = v.b;
    sb.push_back(v);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.A = 8'($urandom); bus_if.B = 8'($urandom); bus_if.op = 3'($urandom);
    check("busy_on_accept", bus_if.busy, 1'b1);
    n = 0; busy_n = 0;
    while (bus_if.done !== 1'b1 && n < 40) begin
      if (bus_if.busy === 1'b1) busy_n++;
      if (n == poke) begin
        bus_if.start = 1'b1; bus_if.op = 3'd0; bus_if.A = 8'h01; bus_if.B = 8'h01;
      end else begin
        bus_if.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus_if.start = 1'b0;
    check("latency", n, v.lat);
    check("busy_cycles", busy_n, v.lat);
    check("busy_at_done", bus_if.busy, 1'b0);
    @(posedge clk); #1;
    check("done_width", bus_if.done, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(3'd0, 8'hC8, 8'h64, 8'h2C, 8'h00, 1'b1, 1'b0, 1'b0, 2);
    tbl[1]  = mk(3'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 2);
    tbl[2]  = mk(3'd1, 8'h05, 8'h07, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 2);
    tbl[3]  = mk(3'd1, 8'h33, 8'h33, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2);
    tbl[4]  = mk(3'd7, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 9);
    tbl[5]  = mk(3'd5, 8'h81, 8'hF3, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 2);
    tbl[6]  = mk(3'd6, 8'h81, 8'h07, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 2);
    tbl[7]  = mk(3'd4, 8'hAA, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2);
    tbl[8]  = mk(3'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 2);
    tbl[9]  = mk(3'd3, 8'hF0, 8'h0F, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 2);
    tbl[10] = mk(3'd7, 8'h00, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 9);
    tbl[11] = mk(3'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 2);
    tbl[12] = mk(3'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 2);

    reset = 1'b0; bus_if.start = 1'b0; bus_if.op = 3'd0; bus_if.A = 8'h00; bus_if.B = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_C", bus_if.C, 8'h00);
    check("rst_C_hi", bus_if.C_hi, 8'h00);
    check("rst_flags", {bus_if.carry, bus_if.overflow, bus_if.zero}, 3'b000);
    check("rst_busy_done", {bus_if.busy, bus_if.done}, 2'b00);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) do_op(tbl[i], -1);

    for (int i = 0; i < 24; i++)
      do_op(model(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)), -1);

    // start pulsed mid-multiply must be ignored
    do_op(mk(3'd7, 8'h12, 8'h34, 8'hA8, 8'h03, 1'b1, 1'b0, 1'b0, 9), 3);
    repeat (4) @(negedge clk);

    // reset mid-multiply at cnt=3
    bus_if.start = 1'b1; bus_if.op = 3'd7; bus_if.A = 8'hFF; bus_if.B = 8'hFF;
    @(posedge clk); #1; bus_if.start = 1'b0;
    repeat (3) @(posedge clk);
    #2; reset = 1'b0; #1;
    check("midrst_C", bus_if.C, 8'h00);
    check("midrst_C_hi", bus_if.C_hi, 8'h00);
    check("midrst_flags", {bus_if.carry, bus_if.overflow, bus_if.zero}, 3'b000);
    check("midrst_busy_done", {bus_if.busy, bus_if.done}, 2'b00);
    @(negedge clk); reset = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_busy", bus_if.busy, 1'b0);
    do_op(mk(3'd0, 8'h01, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 2), -1);

    // start held high: three back-to-back ADDs
    np = 0;
    bus_if.start = 1'b1; bus_if.op = 3'd0; bus_if.A = 8'h01; bus_if.B = 8'h02;
    sb.push_back(model(3'd0, 8'h01, 8'h02));
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1 && np < 4) begin pulses[np] = e; np++; end
      if (e == 0) begin bus_if.A = 8'h03; bus_if.B = 8'h04; sb.push_back(model(3'd0, 8'h03, 8'h04)); end
      if (e == 3) begin bus_if.A = 8'h80; bus_if.B = 8'h80; sb.push_back(model(3'd0, 8'h80, 8'h80)); end
      if (e == 6) bus_if.start = 1'b0;
    end
    check("b2b_count", np, 3);
    for (int i = 0; i < 3; i++) check("b2b_spacing", pulses[i], 2 + 3 * i);

    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
